// File: rtl/decode_issue.sv
// Decode/issue stage: classifies one held instruction, tracks pending writes in a busy-bit scoreboard.
// Define DECODE_ISSUE_FPU_EN to enable the FPR scoreboard, fwb_* port and the FPU class.
`ifndef OP_SPECIAL
`define OP_SPECIAL 6'h00
`endif
`ifndef OP_COP1
`define OP_COP1 6'h11
`endif

module decode_issue #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int MAX_OUT = 4,
    localparam int RW     = $clog2(NREG),
    localparam int CW     = $clog2(MAX_OUT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_op,
    output logic            iss_valid,
    input  logic            iss_ready,
    output logic [2:0]      iss_unit,
    output logic [31:0]     iss_op,
    output logic [XLEN-1:0] iss_imm,
    output logic [RW-1:0]   iss_dst,
    output logic            iss_wr,
    output logic            iss_dst_fp,
    input  logic            gwb_valid,
    input  logic [RW-1:0]   gwb_addr,
    input  logic            fwb_valid,
    input  logic [RW-1:0]   fwb_addr,
    input  logic            br_done,
    output logic [NREG-1:0] busy_gpr,
    output logic [CW-1:0]   out_cnt,
    output logic            illegal,
    output logic            wb_err
);
    localparam logic [2:0] U_ALU = 3'd0, U_LSU = 3'd1, U_FPU = 3'd2;
    localparam logic [2:0] U_BR = 3'd3, U_UART = 3'd4;
    localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0a;
    localparam logic [5:0] OP_SGTI = 6'h0b, OP_ORI = 6'h0d, OP_LUI = 6'h0f;
    localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2b, OP_LWC1 = 6'h31;
    localparam logic [5:0] OP_LWC2 = 6'h32, OP_SWC1 = 6'h39, OP_SWC2 = 6'h3a;

    logic            held;
    logic [31:0]     op_q;
    logic [NREG-1:0] busy_g;
    logic [CW-1:0]   cnt;
    logic            br_pend;

    logic [5:0]    opc;
    logic [RW-1:0] rs, rt, rd, sa, r31;
    logic          d_legal, d_wr, d_fp, g1e, g2e;
    logic [2:0]    d_unit;
    logic [RW-1:0] dst, g1, g2;

    logic            wr_eff, haz, f_haz, full, fire;
    logic [NREG-1:0] g_clr, g_eff, g_set;
    logic            g_dec, g_err, f_dec, f_err;

    assign opc = op_q[31:26];
    assign rs  = RW'(op_q[25:21]);
    assign rt  = RW'(op_q[20:16]);
    assign rd  = RW'(op_q[15:11]);
    assign sa  = RW'(op_q[10:6]);
    assign r31 = RW'(31);

`ifdef DECODE_ISSUE_FPU_EN
    logic            f1e, f2e;
    logic [RW-1:0]   f1, f2;
    logic [NREG-1:0] busy_f, f_clr, f_eff, f_set;
`endif

    always_comb begin
        d_legal = 1'b1;
        d_unit  = U_ALU;
        d_wr    = 1'b0;
        d_fp    = 1'b0;
        dst     = rt;
        g1e     = 1'b0;
        g1      = rs;
        g2e     = 1'b0;
        g2      = rt;
`ifdef DECODE_ISSUE_FPU_EN
        f1e     = 1'b0;
        f1      = rd;
        f2e     = 1'b0;
        f2      = rt;
`endif
        unique case (opc) inside
            `OP_SPECIAL: begin
                dst = rd;
                unique case (op_q[5:0]) inside
                    6'h00, 6'h02, 6'h03: begin
                        d_wr = 1'b1;
                        g2e  = 1'b1;
                    end
                    6'h04, 6'h06, 6'h07, [6'h20:6'h27], [6'h2a:6'h2c]: begin
                        d_wr = 1'b1;
                        g1e  = 1'b1;
                        g2e  = 1'b1;
                    end
                    6'h08: begin
                        d_unit = U_BR;
                        g1e    = 1'b1;
                    end
                    6'h09: begin
                        d_unit = U_BR;
                        g1e    = 1'b1;
                        d_wr   = 1'b1;
                        dst    = r31;
                    end
                    default: d_legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_SGTI, OP_ORI: begin
                d_wr = 1'b1;
                g1e  = 1'b1;
            end
            OP_LUI: d_wr = 1'b1;
            OP_LW: begin
                d_unit = U_LSU;
                d_wr   = 1'b1;
                g1e    = 1'b1;
            end
            OP_SW: begin
                d_unit = U_LSU;
                g1e    = 1'b1;
                g2e    = 1'b1;
            end
            OP_J: d_unit = U_BR;
            OP_JAL: begin
                d_unit = U_BR;
                d_wr   = 1'b1;
                dst    = r31;
            end
            OP_BEQ, OP_BNE: begin
                d_unit = U_BR;
                g1e    = 1'b1;
                g2e    = 1'b1;
            end
            OP_LWC2: begin
                d_unit = U_UART;
                d_wr   = 1'b1;
                dst    = rs;
            end
            OP_SWC2: begin
                d_unit = U_UART;
                g2e    = 1'b1;
            end
`ifdef DECODE_ISSUE_FPU_EN
            OP_LWC1: begin
                d_unit = U_LSU;
                d_wr   = 1'b1;
                d_fp   = 1'b1;
                g1e    = 1'b1;
            end
            OP_SWC1: begin
                d_unit = U_LSU;
                g1e    = 1'b1;
                f2e    = 1'b1;
            end
            `OP_COP1: begin
                d_unit = U_FPU;
                if (op_q[25:21] == 5'h00) begin
                    d_wr = 1'b1;
                    f1e  = 1'b1;
                end else if (op_q[25:21] == 5'h02) begin
                    d_wr = 1'b1;
                    d_fp = 1'b1;
                    dst  = rd;
                end else if (op_q[25:21] == 5'h08 && op_q[20:17] == 4'h0) begin
                    d_unit = U_BR;
                    f1e    = 1'b1;
                    f1     = r31;
                end else if (op_q[25:21] inside {5'h10, 5'h11, 5'h14}) begin
                    d_wr = 1'b1;
                    d_fp = 1'b1;
                    dst  = sa;
                    f1e  = 1'b1;
                    unique case (op_q[5:0]) inside
                        [6'h00:6'h03]: f2e = 1'b1;
                        6'h06, 6'h20, 6'h21, 6'h24: f2e = 1'b0;
                        [6'h30:6'h3f]: begin
                            f2e = 1'b1;
                            dst = r31;
                        end
                        default: d_legal = 1'b0;
                    endcase
                end else begin
                    d_legal = 1'b0;
                end
            end
`endif
            default: d_legal = 1'b0;
        endcase
    end

    // GPR 0 is a sink: writes to it neither occupy a busy bit nor count as outstanding
    assign wr_eff = d_legal && d_wr && (d_fp || dst != '0);
    assign g_clr  = gwb_valid ? (NREG'(1) << gwb_addr) & busy_g : '0;
    assign g_eff  = busy_g & ~g_clr;
    assign g_set  = (fire && wr_eff && !d_fp) ? NREG'(1) << dst : '0;
    assign g_dec  = |g_clr;
    assign g_err  = gwb_valid && !busy_g[gwb_addr];

`ifdef DECODE_ISSUE_FPU_EN
    assign f_clr = fwb_valid ? (NREG'(1) << fwb_addr) & busy_f : '0;
    assign f_eff = busy_f & ~f_clr;
    assign f_set = (fire && wr_eff && d_fp) ? NREG'(1) << dst : '0;
    assign f_dec = |f_clr;
    assign f_err = fwb_valid && !busy_f[fwb_addr];
    assign f_haz = (f1e && f_eff[f1]) || (f2e && f_eff[f2]) ||
                   (wr_eff && d_fp && f_eff[dst]);
`else
    logic unused_fwb;
    assign unused_fwb = ^{fwb_valid, fwb_addr};
    assign f_dec = 1'b0;
    assign f_err = 1'b0;
    assign f_haz = 1'b0;
`endif

    // writebacks landing this cycle release their registers for the held op
    assign haz = (g1e && g_eff[g1]) || (g2e && g_eff[g2]) ||
                 (wr_eff && !d_fp && g_eff[dst]) || f_haz;
    assign full      = wr_eff && cnt == CW'(MAX_OUT);
    assign iss_valid = held && d_legal && !haz && !full;
    assign fire      = iss_valid && iss_ready;
    // no capture behind a branch until the pc has resolved it
    assign in_ready  = !br_pend && (!held || (fire && d_unit != U_BR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held    <= 1'b0;
            op_q    <= '0;
            busy_g  <= '0;
            cnt     <= '0;
            br_pend <= 1'b0;
            wb_err  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            illegal <= held && !d_legal;
            if (in_valid && in_ready) begin
                held <= 1'b1;
                op_q <= in_op;
            end else if (fire || (held && !d_legal)) begin
                held <= 1'b0;
            end
            busy_g <= g_eff | g_set;
            cnt    <= cnt + CW'(fire && wr_eff) - CW'(g_dec) - CW'(f_dec);
            if (fire && d_unit == U_BR)
                br_pend <= 1'b1;
            else if (br_done)
                br_pend <= 1'b0;
            if (g_err || f_err)
                wb_err <= 1'b1;
        end
    end

`ifdef DECODE_ISSUE_FPU_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy_f <= '0;
        else
            busy_f <= f_eff | f_set;
    end
`endif

    assign iss_unit   = d_unit;
    assign iss_op     = op_q;
    assign iss_imm    = (opc == OP_ORI) ? {{(XLEN-16){1'b0}}, op_q[15:0]}
                                        : {{(XLEN-16){op_q[15]}}, op_q[15:0]};
    assign iss_dst    = dst;
    assign iss_wr     = wr_eff;
    assign iss_dst_fp = d_fp;
    assign busy_gpr   = busy_g;
    assign out_cnt    = cnt;
endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: a decode vector table plus scoreboard,
// branch, writeback and reset sequences (MAX_OUT=2).
module tb_decode_issue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_op = '0;
    logic        iss_valid, iss_ready = 1'b0;
    logic [2:0]  iss_unit;
    logic [31:0] iss_op, iss_imm;
    logic [4:0]  iss_dst;
    logic        iss_wr, iss_dst_fp;
    logic        gwb_valid = 1'b0, fwb_valid = 1'b0, br_done = 1'b0;
    logic [4:0]  gwb_addr = '0, fwb_addr = '0;
    logic [31:0] busy_gpr;
    logic [1:0]  out_cnt;
    logic        illegal, wb_err;

    int pass_cnt = 0;
    int total = 0;

    decode_issue #(.XLEN(32), .NREG(32), .MAX_OUT(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_unit(iss_unit), .iss_op(iss_op), .iss_imm(iss_imm),
        .iss_dst(iss_dst), .iss_wr(iss_wr), .iss_dst_fp(iss_dst_fp),
        .gwb_valid(gwb_valid), .gwb_addr(gwb_addr),
        .fwb_valid(fwb_valid), .fwb_addr(fwb_addr),
        .br_done(br_done), .busy_gpr(busy_gpr), .out_cnt(out_cnt),
        .illegal(illegal), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op;
        logic        legal;
        logic [2:0]  unit;
        logic [31:0] imm;
        logic        wr;
        logic [4:0]  dst;
    } vec_t;

    function automatic logic [31:0] ei(input logic [5:0] o, input logic [4:0] s,
                                       input logic [4:0] t, input logic [15:0] im);
        return {o, s, t, im};
    endfunction

    function automatic logic [31:0] er(input logic [4:0] s, input logic [4:0] t,
                                       input logic [4:0] d, input logic [5:0] fn);
        return {6'h00, s, t, d, 5'h00, fn};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        iss_ready = 1'b0;
        gwb_valid = 1'b0;
        fwb_valid = 1'b0;
        br_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    vec_t vt[$];

    initial begin
        vt.push_back('{ei(6'h08, 0, 1, 16'hfffd), 1, 3'd0, 32'hfffffffd, 1, 5'd1});
        vt.push_back('{ei(6'h0d, 0, 2, 16'h8001), 1, 3'd0, 32'h00008001, 1, 5'd2});
        vt.push_back('{ei(6'h0f, 0, 5, 16'h1234), 1, 3'd0, 32'h00001234, 1, 5'd5});
        vt.push_back('{er(1, 2, 3, 6'h20), 1, 3'd0, 32'h00001820, 1, 5'd3});
        vt.push_back('{ei(6'h23, 1, 4, 16'h0008), 1, 3'd1, 32'h00000008, 1, 5'd4});
        vt.push_back('{ei(6'h2b, 1, 4, 16'hfffc), 1, 3'd1, 32'hfffffffc, 0, 5'd0});
        vt.push_back('{ei(6'h04, 1, 2, 16'h0010), 1, 3'd3, 32'h00000010, 0, 5'd0});
        vt.push_back('{{6'h03, 26'h10}, 1, 3'd3, 32'h00000010, 1, 5'd31});
        vt.push_back('{er(1, 0, 0, 6'h08), 1, 3'd3, 32'h00000008, 0, 5'd0});
        vt.push_back('{ei(6'h32, 9, 0, 16'h0000), 1, 3'd4, 32'h00000000, 1, 5'd9});
        vt.push_back('{ei(6'h3a, 0, 7, 16'h0004), 1, 3'd4, 32'h00000004, 0, 5'd0});
        vt.push_back('{ei(6'h08, 0, 0, 16'h0001), 1, 3'd0, 32'h00000001, 0, 5'd0});
        vt.push_back('{32'hfc000000, 0, 3'd0, 32'h0, 0, 5'd0});
        vt.push_back('{er(1, 2, 3, 6'h3f), 0, 3'd0, 32'h0, 0, 5'd0});
`ifdef DECODE_ISSUE_FPU_EN
        vt.push_back('{{6'h11, 5'h10, 5'd2, 5'd1, 5'd4, 6'h00}, 1, 3'd2, 32'h00000900, 1, 5'd4});
`else
        vt.push_back('{{6'h11, 5'h10, 5'd2, 5'd1, 5'd4, 6'h00}, 0, 3'd0, 32'h0, 0, 5'd0});
`endif

        do_reset();
        #1;
        chk("rst_iss_valid", 32'(iss_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_busy", busy_gpr, 0);
        chk("rst_cnt", 32'(out_cnt), 0);
        chk("rst_wb_err", 32'(wb_err), 0);
        chk("rst_illegal", 32'(illegal), 0);

        foreach (vt[i]) begin
            do_reset();
            in_valid = 1'b1;
            in_op = vt[i].op;
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk($sformatf("v%0d_valid", i), 32'(iss_valid), 32'(vt[i].legal));
            if (vt[i].legal) begin
                chk($sformatf("v%0d_unit", i), 32'(iss_unit), 32'(vt[i].unit));
                chk($sformatf("v%0d_imm", i), iss_imm, vt[i].imm);
                chk($sformatf("v%0d_wr", i), 32'(iss_wr), 32'(vt[i].wr));
                if (vt[i].wr) chk($sformatf("v%0d_dst", i), 32'(iss_dst), 32'(vt[i].dst));
            end else begin
                cyc();
                chk($sformatf("v%0d_illegal", i), 32'(illegal), 1);
            end
        end

        // RAW stall until writeback of r1
        do_reset();
        iss_ready = 1'b1;
        in_valid = 1'b1;
        in_op = ei(6'h08, 0, 1, 16'd5);
        @(negedge clk);
        in_op = er(1, 1, 2, 6'h20);
        #1;
        chk("raw_addi_valid", 32'(iss_valid), 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("raw_stall", 32'(iss_valid), 0);
        chk("raw_busy", busy_gpr, 32'h2);
        chk("raw_cnt", 32'(out_cnt), 1);
        cyc();
        cyc();
        chk("raw_still_stall", 32'(iss_valid), 0);
        @(negedge clk);
        gwb_valid = 1'b1;
        gwb_addr = 5'd1;
        #1;
        chk("raw_release", 32'(iss_valid), 1);
        chk("raw_dst", 32'(iss_dst), 2);
        @(negedge clk);
        gwb_valid = 1'b0;
        #1;
        chk("raw_busy_after", busy_gpr, 32'h4);
        chk("raw_cnt_after", 32'(out_cnt), 1);
        chk("raw_wb_err", 32'(wb_err), 0);

        // outstanding limit
        do_reset();
        iss_ready = 1'b1;
        in_valid = 1'b1;
        in_op = ei(6'h23, 0, 3, 16'h0);
        @(negedge clk);
        in_op = ei(6'h23, 0, 4, 16'h0);
        @(negedge clk);
        in_op = ei(6'h23, 0, 5, 16'h0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("full_cnt", 32'(out_cnt), 2);
        chk("full_stall", 32'(iss_valid), 0);
        chk("full_busy", busy_gpr, 32'h18);
        @(negedge clk);
        gwb_valid = 1'b1;
        gwb_addr = 5'd3;
        #1;
        chk("full_wb_cycle", 32'(iss_valid), 0);
        @(negedge clk);
        gwb_valid = 1'b0;
        #1;
        chk("full_release", 32'(iss_valid), 1);
        chk("full_dst", 32'(iss_dst), 5);
        cyc();
        chk("full_cnt2", 32'(out_cnt), 2);
        chk("full_busy2", busy_gpr, 32'h30);

        // branch blocks capture until br_done
        do_reset();
        iss_ready = 1'b1;
        in_valid = 1'b1;
        in_op = ei(6'h04, 0, 0, 16'h4);
        @(negedge clk);
        in_op = ei(6'h08, 0, 8, 16'h1);
        #1;
        chk("br_valid", 32'(iss_valid), 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 4) br_done = 1'b1;
            #1;
            chk($sformatf("br_block%0d", k), 32'(in_ready), 0);
        end
        @(negedge clk);
        br_done = 1'b0;
        #1;
        chk("br_ready", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("br_next_valid", 32'(iss_valid), 1);
        chk("br_next_dst", 32'(iss_dst), 8);

        // same-cycle writeback and reissue of r6
        do_reset();
        iss_ready = 1'b1;
        in_valid = 1'b1;
        in_op = ei(6'h23, 0, 6, 16'h0);
        @(negedge clk);
        in_op = ei(6'h08, 0, 6, 16'h1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("waw_stall", 32'(iss_valid), 0);
        @(negedge clk);
        gwb_valid = 1'b1;
        gwb_addr = 5'd6;
        #1;
        chk("waw_release", 32'(iss_valid), 1);
        @(negedge clk);
        gwb_valid = 1'b0;
        #1;
        chk("waw_busy", busy_gpr, 32'h40);
        chk("waw_cnt", 32'(out_cnt), 1);

`ifdef DECODE_ISSUE_FPU_EN
        do_reset();
        iss_ready = 1'b1;
        in_valid = 1'b1;
        in_op = {6'h11, 5'h10, 5'd2, 5'd1, 5'd4, 6'h00};
        @(negedge clk);
        in_op = {6'h11, 5'h00, 5'd7, 5'd4, 11'h0};
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("fpu_stall", 32'(iss_valid), 0);
        @(negedge clk);
        fwb_valid = 1'b1;
        fwb_addr = 5'd4;
        #1;
        chk("fpu_release", 32'(iss_valid), 1);
        chk("fpu_unit", 32'(iss_unit), 2);
        chk("fpu_dst", 32'(iss_dst), 7);
        chk("fpu_dst_fp", 32'(iss_dst_fp), 0);
        @(negedge clk);
        fwb_valid = 1'b0;
`endif

        // stray writeback, then reset during a stall
        do_reset();
        gwb_valid = 1'b1;
        gwb_addr = 5'd9;
        @(negedge clk);
        gwb_valid = 1'b0;
        #1;
        chk("stray_wb_err", 32'(wb_err), 1);
        chk("stray_cnt", 32'(out_cnt), 0);
        do_reset();
        iss_ready = 1'b1;
        in_valid = 1'b1;
        in_op = ei(6'h23, 0, 3, 16'h0);
        @(negedge clk);
        in_op = er(3, 3, 4, 6'h20);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("mid_stall", 32'(iss_valid), 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy_gpr, 0);
        chk("mid_rst_valid", 32'(iss_valid), 0);
        chk("mid_rst_cnt", 32'(out_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        gwb_valid = 1'b1;
        gwb_addr = 5'd3;
        @(negedge clk);
        gwb_valid = 1'b0;
        #1;
        chk("late_wb_err", 32'(wb_err), 1);
        chk("late_valid", 32'(iss_valid), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
